// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART Sender among N_REQ valid/ready byte producers.
// Latches the winning byte, pulses START, then follows BUSY until the frame completes.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic [2:0]         grant_id,
    output logic               idle,
    output logic               err
);

    typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

    // Counter value on the last waiting cycle before the timeout fires.
    localparam logic [7:0] CntLast = 8'(BUSY_TIMEOUT - 2);

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [2:0]         last_q, last_d;
    logic [7:0]         data_q, data_d;
    logic [2:0]         gid_q, gid_d;
    logic [N_REQ-1:0]   ready_q, ready_d;
    logic               start_q, start_d;
    logic               err_q, err_d;
    logic               idle_q, idle_d;

    logic [7:0]         valid_ext;
    logic [2:0]         cand;
    logic               win_found;
    logic [2:0]         win_idx;
    logic [7:0]         win_data;
    logic [N_REQ-1:0]   win_onehot;

    assign valid_ext = 8'(req_valid);

    // Search last+1, last+2, ... modulo N_REQ; first pending requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = 3'((32'(last_q) + k) % N_REQ);
            if (!win_found && valid_ext[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_data   = '0;
        win_onehot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_idx == 3'(i)) begin
                win_data      = req_data[8*i +: 8];
                win_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        data_d  = data_q;
        gid_d   = gid_q;
        ready_d = '0;
        start_d = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (!tx_busy && win_found) begin
                    data_d  = win_data;
                    gid_d   = win_idx;
                    last_d  = win_idx;
                    ready_d = win_onehot;
                    start_d = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        idle_d = (state_d == StIdle) && !tx_busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= 3'(N_REQ - 1);
            data_q  <= '0;
            gid_q   <= '0;
            ready_q <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            ready_q <= ready_d;
            start_q <= start_d;
            err_q   <= err_d;
            idle_q  <= idle_d;
        end
    end

    assign req_ready = ready_q;
    assign tx_data   = data_q;
    assign tx_start  = start_q;
    assign grant_id  = gid_q;
    assign idle      = idle_q;
    assign err       = err_q;

endmodule
